// File: rtl/rrotate16_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rrotate16_seq
//  Description : Sequential 16-bit right-rotate unit. A start request latches
//                an operand and a rotate amount. The working register is then
//                rotated one bit per clock until the requested amount has been
//                applied. The result is published on OUT together with a
//                one-cycle done pulse.
//
//  Optional feature
//    RROTATE16_STEP4_EN : when defined, the ROT state rotates by a whole
//                         nibble (4 bits) per clock while at least 4 steps
//                         remain. The remainder is handled one bit at a time.
//                         Latency drops from n+1 to floor(n/4)+(n mod 4)+1
//                         edges. Results are identical in both builds.
//
//  Ports
//    clk   in   1  : clock, all state updates on the rising edge
//    rst   in   1  : asynchronous, active-high reset
//    start in   1  : begin a rotate (honoured only in IDLE)
//    A     in  16  : operand, sampled with start
//    shr   in   4  : right-rotate amount 0..15, sampled with start
//    busy  out  1  : high in ROT and DONE
//    done  out  1  : one-cycle pulse, OUT holds a new result
//    OUT   out 16  : registered result of the last completed rotate
//
//  Revision    : 1.0  initial release
// ============================================================================
module rrotate16_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [3:0]  shr,
  output logic        busy,
  output logic        done,
  output logic [15:0] OUT
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROT  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] C_CNT_ZERO = 4'd0;
  localparam logic [3:0] C_CNT_ONE  = 4'd1;

  // --------------------------------------------------------------------------
  // Registers and their next-state values
  // --------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_work;       // operand being rotated
  logic [15:0] w_work_nxt;
  logic [3:0]  r_cnt;        // rotate steps still to apply
  logic [3:0]  w_cnt_nxt;
  logic [15:0] r_out;        // published result
  logic [15:0] w_out_nxt;

  // One ROT-state step: the rotated working value and the remaining count.
  logic [15:0] w_step_work;
  logic [3:0]  w_step_cnt;

`ifdef RROTATE16_STEP4_EN
  // A whole-nibble rotate is only taken while at least four steps remain, so
  // the counter can never wrap below zero.
  logic w_big_step;

  assign w_big_step  = (r_cnt >= 4'd4);
  assign w_step_work = w_big_step ? {r_work[3:0], r_work[15:4]}
                                  : {r_work[0],   r_work[15:1]};
  assign w_step_cnt  = w_big_step ? (r_cnt - 4'd4) : (r_cnt - C_CNT_ONE);
`else
  // Single-bit right rotate: bit 0 wraps around into bit 15.
  assign w_step_work = {r_work[0], r_work[15:1]};
  assign w_step_cnt  = r_cnt - C_CNT_ONE;
`endif

  // --------------------------------------------------------------------------
  // Next-state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_work_nxt = A;
          w_cnt_nxt  = shr;
          if (shr == C_CNT_ZERO) begin
            // Nothing to rotate: publish the operand directly.
            w_out_nxt   = A;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ROT;
          end
        end
      end

      S_ROT: begin
        // start is deliberately not looked at here; the operation in flight
        // only depends on the values captured in IDLE.
        w_work_nxt = w_step_work;
        w_cnt_nxt  = w_step_cnt;
        if (w_step_cnt == C_CNT_ZERO) begin
          // The final step lands in OUT on the same edge that enters DONE.
          w_out_nxt   = w_step_work;
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_work  <= 16'h0000;
      r_cnt   <= C_CNT_ZERO;
      r_out   <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs are decoded straight from registered state. Reset therefore clears
  // them at once, without waiting for a clock edge.
  // --------------------------------------------------------------------------
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign OUT  = r_out;

endmodule
`default_nettype wire

// File: tb/tb_rrotate16_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rrotate16_seq
//  Description : Self-checking bench for rrotate16_seq. It applies a table of
//                directed vectors, hand-written sequences for the ignored-start
//                and mid-operation-reset cases, a sweep of every shift amount,
//                and a randomized run. Expected values come from a
//                rotate-by-indexing reference model and from closed-form
//                latency formulas.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rrotate16_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start;
  logic [15:0] A;
  logic [3:0]  shr;
  logic        busy;
  logic        done;
  logic [15:0] OUT;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rrotate16_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .shr   (shr),
    .busy  (busy),
    .done  (done),
    .OUT   (OUT)
  );

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  // Right rotate by n: take a 16-bit window out of the operand doubled.
  function automatic logic [15:0] ref_ror(input logic [15:0] a, input int n);
    logic [31:0] w;
    w = {a, a};
    return w[n +: 16];
  endfunction

  // Left rotate by m, written with plain shifts.
  function automatic logic [15:0] ref_rol(input logic [15:0] a, input int m);
    int unsigned v;
    v = 32'(a);
    return 16'(((v << m) | (v >> (16 - m))) & 32'hFFFF);
  endfunction

  function automatic int ref_lat(input int n);
`ifdef RROTATE16_STEP4_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance past a rising edge. Outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to completion. With noisy set, the
  // inputs are scrambled and start is toggled while the operation runs.
  task automatic run_op(input logic [15:0] a, input logic [3:0] n,
                        input logic [15:0] exp_out, input int exp_lat,
                        input string name, input bit noisy);
    int          edges;
    bit          hold_ok;
    bit          busy_ok;
    logic [15:0] prev;
    prev  = OUT;
    start = 1'b1;
    A     = a;
    shr   = n;
    tick();
    edges = 1;
    start = 1'b0;
    if (noisy) begin
      A   = 16'($urandom);
      shr = 4'($urandom);
    end
    hold_ok = 1'b1;
    busy_ok = 1'b1;
    while (!done && edges < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (OUT !== prev) hold_ok = 1'b0;
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        A     = 16'($urandom);
        shr   = 4'($urandom);
      end
      tick();
      edges++;
    end
    check({name, " done"}, int'(done), 1);
    check({name, " latency"}, edges, exp_lat);
    check({name, " OUT"}, int'(OUT), int'(exp_out));
    check({name, " busy@done"}, int'(busy), 1);
    check({name, " busy-while-run"}, int'(busy_ok), 1);
    check({name, " OUT-hold"}, int'(hold_ok), 1);
    tick();
    start = 1'b0;
    check({name, " done-pulse-width"}, int'(done), 0);
    check({name, " idle-after"}, int'(busy), 0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [3:0]  n;
    logic [15:0] exp_out;
    int          exp_lat;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int          edges;
    int          rst_edge;
    bit          saw_done;
    bit          quiet_ok;
    logic [15:0] ra;
    logic [3:0]  rn;

    // Directed vectors. Latencies are written out per build.
    tbl[0] = '{16'h0003, 4'd8,  16'h0300, 9};
    tbl[1] = '{16'h0003, 4'd1,  16'h8001, 2};
    tbl[2] = '{16'h8000, 4'd15, 16'h0001, 16};
    tbl[3] = '{16'hBEEF, 4'd0,  16'hBEEF, 1};
`ifdef RROTATE16_STEP4_EN
    tbl[0].exp_lat = 3;
    tbl[2].exp_lat = 7;
`endif

    start = 1'b0;
    A     = 16'h0000;
    shr   = 4'd0;

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset OUT", int'(OUT), 0);
    tick();
    tick();
    rst = 1'b0;

    // The first request right after reset release is accepted on the next edge.
    foreach (tbl[i])
      run_op(tbl[i].a, tbl[i].n, tbl[i].exp_out, tbl[i].exp_lat,
             $sformatf("vec%0d", i), 1'b0);

    // A second start issued while busy is ignored and is not queued.
    start = 1'b1;
    A     = 16'h1234;
    shr   = 4'd4;
    tick();
    A     = 16'hFFFF;
    shr   = 4'd3;
    tick();
    edges = 2;
    start = 1'b0;
    while (!done && edges < 40) begin
      tick();
      edges++;
    end
    check("ignore done", int'(done), 1);
    check("ignore latency", edges, ref_lat(4));
    check("ignore OUT", int'(OUT), 16'h4123);
    quiet_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (busy || done || OUT !== 16'h4123) quiet_ok = 1'b0;
    end
    check("ignore no-second-op", int'(quiet_ok), 1);

    // Reset asserted in the middle of an operation aborts it.
`ifdef RROTATE16_STEP4_EN
    rst_edge = 2;
`else
    rst_edge = 5;
`endif
    start    = 1'b1;
    A        = 16'h00F0;
    shr      = 4'd12;
    tick();
    start    = 1'b0;
    edges    = 1;
    saw_done = 1'b0;
    while (edges < rst_edge) begin
      tick();
      edges++;
      if (done) saw_done = 1'b1;
    end
    rst = 1'b1;
    #2;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort OUT", int'(OUT), 0);
    check("abort no-early-done", int'(saw_done), 0);
    tick();
    check("abort held done", int'(done), 0);
    rst = 1'b0;
    run_op(16'h00F0, 4'd12, 16'h0F00, ref_lat(12), "after-abort", 1'b0);

    // Every rotate amount, checked against a left-rotate formulation.
    for (int n = 0; n < 16; n++)
      run_op(16'hA5C3, 4'(n), ref_rol(16'hA5C3, (16 - n) % 16), ref_lat(n),
             $sformatf("sweep%0d", n), 1'b0);

    // Random operands with input noise during each operation.
    for (int r = 0; r < 24; r++) begin
      ra = 16'($urandom);
      rn = 4'($urandom_range(0, 15));
      run_op(ra, rn, ref_ror(ra, int'(rn)), ref_lat(int'(rn)),
             $sformatf("rand%0d", r), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
